// File: rtl/x2_seq_div.sv
// Restoring sequential divider, one quotient bit per clock, start/done handshake.
// Divide-by-zero and signed overflow produce RISC-V M-extension results.
module x2_seq_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0]  dvd_q, dvd_d;       // working dividend, becomes quotient magnitude
  logic [WIDTH-1:0]  dvs_q, dvs_d;       // divisor magnitude
  logic              neg_q_q, neg_q_d;   // negate quotient at the end
  logic              neg_r_q, neg_r_d;   // negate remainder at the end
  logic              done_q, done_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  res_q, res_d;

  logic              dvd_neg, dvs_neg;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    diff;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];

  // Fits in WIDTH+1 bits: shifted < 2*divisor, so a set MSB means it went negative.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    res_d   = res_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d  = '1;
            res_d  = dividend;
            done_d = 1'b1;
          end else begin
            neg_q_d = dvd_neg ^ dvs_neg;
            neg_r_d = dvd_neg;
            dvd_d   = dvd_neg ? -dividend : dividend;
            dvs_d   = dvs_neg ? -divisor : divisor;
            rem_d   = '0;
            cnt_d   = CntW'(WIDTH);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
        end else begin
          rem_d = shifted[WIDTH-1:0];
        end
        dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StSign;
        end
      end
      StSign: begin
        quo_d   = neg_q_q ? -dvd_q : dvd_q;
        res_d   = neg_r_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = res_q;

endmodule
